// File: rtl/uram_arbiter.sv
// ---------------------------------------------------------------------------
// uram_arbiter
//
// Purpose:
//   Shares one single-port, 72-bit, byte-write URAM between a video fetch
//   port (full-word reads) and a CPU/mapper port (byte reads and writes).
//   The block drives every RAM control pin, optionally clears the whole
//   array after reset, and routes read data back to whichever port issued
//   the read, with a fixed two-cycle latency measured from the grant pulse.
//
// Optional feature:
//   URAM_ARB_CLEAR_EN - when defined, a CLEAR state writes zero to every word
//   (0..DEPTH-1) before any request is served. When undefined, serving
//   starts on the first edge after reset release and RAM contents are left
//   as they are.
//
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   vid_req/vid_addr        video word-read request (held until vid_gnt)
//   vid_gnt                 one-cycle grant pulse to video
//   vid_rvalid/vid_rdata    returned 72-bit word
//   cpu_req/cpu_we/
//   cpu_addr/cpu_wdata      CPU byte request (held until cpu_gnt)
//   cpu_gnt                 one-cycle grant pulse to CPU
//   cpu_rvalid/cpu_rdata    returned byte
//   ram_we/ram_addr/ram_di  registered RAM command (9 lane write enables)
//   ram_do                  RAM read data, valid one cycle after ram_addr
//   init_done               high once serving has started
// ---------------------------------------------------------------------------
module uram_arbiter #(
    parameter int DEPTH        = 262144,
    parameter int ADDR_WIDTH   = 18,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_gnt,
    output logic                  vid_rvalid,
    output logic [71:0]           vid_rdata,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH+2:0] cpu_addr,
    input  logic [7:0]            cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [7:0]            cpu_rdata,
    output logic [8:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [71:0]           ram_di,
    input  logic [71:0]           ram_do,
    output logic                  init_done
);

    // Parameter sanity, caught at elaboration.
    if ((64'd1 << ADDR_WIDTH) < 64'(DEPTH)) begin : g_bad_depth
        $error("uram_arbiter: 2**ADDR_WIDTH must be >= DEPTH");
    end
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
        $error("uram_arbiter: STARVE_LIMIT must be 1..255");
    end

    logic                  vid_gnt_q,    vid_gnt_d;
    logic                  cpu_gnt_q,    cpu_gnt_d;
    logic                  vid_rvalid_q, vid_rvalid_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic [71:0]           vid_rdata_q,  vid_rdata_d;
    logic [7:0]            cpu_rdata_q,  cpu_rdata_d;
    logic [8:0]            ram_we_q,     ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
    logic [71:0]           ram_di_q,     ram_di_d;
    logic                  init_done_q,  init_done_d;
    logic [7:0]            starve_q,     starve_d;

    // Read tag pipe: stage 1 tracks the RAM address cycle, stage 2 the
    // cycle in which ram_do holds the data. port = 1 means CPU.
    logic                  t1_valid_q, t1_valid_d;
    logic                  t1_port_q,  t1_port_d;
    logic [2:0]            t1_lane_q,  t1_lane_d;
    logic                  t2_valid_q, t2_valid_d;
    logic                  t2_port_q,  t2_port_d;
    logic [2:0]            t2_lane_q,  t2_lane_d;

    logic                  serving;
    logic                  vid_elig;
    logic                  cpu_elig;
    logic                  cpu_win;
    logic [2:0]            cpu_lane;
    logic [ADDR_WIDTH-1:0] cpu_word;

`ifdef URAM_ARB_CLEAR_EN
    typedef enum logic {ST_CLEAR, ST_SERVE} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
    assign serving = (state_q == ST_SERVE);
`else
    assign serving = init_done_q;
`endif

    assign cpu_lane = cpu_addr[2:0];
    assign cpu_word = cpu_addr[ADDR_WIDTH+2:3];

    // A port granted on the previous edge sits out one edge, so its
    // requester has time to drop or change the request.
    assign vid_elig = vid_req & ~vid_gnt_q;
    assign cpu_elig = cpu_req & ~cpu_gnt_q;
    assign cpu_win  = cpu_elig & ((starve_q >= 8'(STARVE_LIMIT)) | ~vid_elig);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vid_gnt_q    <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vid_rdata_q  <= '0;
            cpu_rdata_q  <= '0;
            ram_we_q     <= '0;
            ram_addr_q   <= '0;
            ram_di_q     <= '0;
            init_done_q  <= 1'b0;
            starve_q     <= '0;
            t1_valid_q   <= 1'b0;
            t1_port_q    <= 1'b0;
            t1_lane_q    <= '0;
            t2_valid_q   <= 1'b0;
            t2_port_q    <= 1'b0;
            t2_lane_q    <= '0;
`ifdef URAM_ARB_CLEAR_EN
            state_q      <= ST_CLEAR;
            clr_ptr_q    <= '0;
`endif
        end else begin
            vid_gnt_q    <= vid_gnt_d;
            cpu_gnt_q    <= cpu_gnt_d;
            vid_rvalid_q <= vid_rvalid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vid_rdata_q  <= vid_rdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_di_q     <= ram_di_d;
            init_done_q  <= init_done_d;
            starve_q     <= starve_d;
            t1_valid_q   <= t1_valid_d;
            t1_port_q    <= t1_port_d;
            t1_lane_q    <= t1_lane_d;
            t2_valid_q   <= t2_valid_d;
            t2_port_q    <= t2_port_d;
            t2_lane_q    <= t2_lane_d;
`ifdef URAM_ARB_CLEAR_EN
            state_q      <= state_d;
            clr_ptr_q    <= clr_ptr_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        vid_gnt_d    = 1'b0;
        cpu_gnt_d    = 1'b0;
        vid_rvalid_d = 1'b0;
        cpu_rvalid_d = 1'b0;
        vid_rdata_d  = vid_rdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        ram_we_d     = '0;
        ram_addr_d   = ram_addr_q;
        ram_di_d     = ram_di_q;
        init_done_d  = init_done_q;
        starve_d     = starve_q;
        t1_valid_d   = 1'b0;
        t1_port_d    = 1'b0;
        t1_lane_d    = '0;
        t2_valid_d   = t1_valid_q;
        t2_port_d    = t1_port_q;
        t2_lane_d    = t1_lane_q;

        // Read return: ram_do belongs to the read tracked in stage 2.
        if (t2_valid_q) begin
            if (t2_port_q) begin
                cpu_rvalid_d = 1'b1;
                cpu_rdata_d  = ram_do[{t2_lane_q, 3'b000} +: 8];
            end else begin
                vid_rvalid_d = 1'b1;
                vid_rdata_d  = ram_do;
            end
        end

`ifdef URAM_ARB_CLEAR_EN
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == ST_CLEAR) begin
            ram_we_d   = 9'h1FF;
            ram_di_d   = '0;
            ram_addr_d = clr_ptr_q;
            clr_ptr_d  = clr_ptr_q + ADDR_WIDTH'(1);
            if (clr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                state_d     = ST_SERVE;
                init_done_d = 1'b1;
            end
        end
`else
        init_done_d = 1'b1;
`endif

        if (serving) begin
            if (cpu_win) begin
                cpu_gnt_d  = 1'b1;
                starve_d   = '0;
                ram_addr_d = cpu_word;
                if (cpu_we) begin
                    ram_we_d = 9'h001 << cpu_lane;
                    ram_di_d = '0;
                    ram_di_d[{cpu_lane, 3'b000} +: 8] = cpu_wdata;
                end else begin
                    t1_valid_d = 1'b1;
                    t1_port_d  = 1'b1;
                    t1_lane_d  = cpu_lane;
                end
            end else if (vid_elig) begin
                vid_gnt_d  = 1'b1;
                ram_addr_d = vid_addr;
                t1_valid_d = 1'b1;
                t1_port_d  = 1'b0;
                if (cpu_elig && starve_q != 8'hFF) begin
                    starve_d = starve_q + 8'd1;
                end
            end
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        vid_gnt    = vid_gnt_q;
        cpu_gnt    = cpu_gnt_q;
        vid_rvalid = vid_rvalid_q;
        cpu_rvalid = cpu_rvalid_q;
        vid_rdata  = vid_rdata_q;
        cpu_rdata  = cpu_rdata_q;
        ram_we     = ram_we_q;
        ram_addr   = ram_addr_q;
        ram_di     = ram_di_q;
        init_done  = init_done_q;
    end

endmodule
